// File: rtl/regs_pkg.sv
// Shared definitions for the multi-port register file (regs_mp).
// Holds the default data width and register count, and the state type
// of the clear sequencer.
package regs_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } regs_state_e;

endpackage : regs_pkg

// File: rtl/regs_rd_port.sv
// One registered read port of the register file.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   busy       : clear sequencer running; output forced to zero
//   rd_en      : read enable; output holds when low
//   addr       : read address
//   regs_flat  : flattened register array, entry i in [i*XLEN +: XLEN]
//   wr_en/wr_addr/wr_data : committed write (only with REGS_MP_BYPASS_EN)
//   rd_data    : registered read data
// Build option: REGS_MP_BYPASS_EN forwards same-edge write data to the read.
module regs_rd_port
  import regs_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  busy,
  input  logic                  rd_en,
  input  logic [AW-1:0]         addr,
  input  logic [NREGS*XLEN-1:0] regs_flat,
`ifdef REGS_MP_BYPASS_EN
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
`endif
  output logic [XLEN-1:0]       rd_data
);

  logic [XLEN-1:0] rd_data_q;
  logic [XLEN-1:0] rd_data_d;

  // Read mux with x0 hard-wired to zero and hold when disabled.
  always_comb begin
    rd_data_d = rd_data_q;
    if (busy) begin
      rd_data_d = '0;
    end else if (rd_en) begin
      if (addr == '0) begin
        rd_data_d = '0;
`ifdef REGS_MP_BYPASS_EN
      end else if (wr_en && (wr_addr == addr)) begin
        rd_data_d = wr_data;
`endif
      end else begin
        rd_data_d = regs_flat[32'(addr) * XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule : regs_rd_port

// File: rtl/regs_mp.sv
// Multi-port register file with x0 hard-wired to zero and a post-reset
// clear sequencer that zeroes x1..x(NREGS-1), one register per cycle.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   rs_rd_en    : per-port read enable (NRD bits)
//   rs_addr     : read addresses, port p in [p*AW +: AW]
//   rd, rd_wr_data, rd_wr_en : write address, data, enable
//   rs_rd_data  : registered read data, port p in [p*XLEN +: XLEN]
//   busy        : clear sequencer running; accesses ignored
// Build option: REGS_MP_BYPASS_EN enables write-to-read forwarding.
module regs_mp
  import regs_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NRD-1:0]                  rs_rd_en,
  input  logic [NRD*$clog2(NREGS)-1:0]    rs_addr,
  input  logic [$clog2(NREGS)-1:0]        rd,
  input  logic [XLEN-1:0]                 rd_wr_data,
  input  logic                            rd_wr_en,
  output logic [NRD*XLEN-1:0]             rs_rd_data,
  output logic                            busy
);

  localparam int unsigned AW = $clog2(NREGS);

  regs_state_e           state_q, state_d;
  logic [AW-1:0]         ptr_q, ptr_d;
  logic                  busy_q, busy_d;
  logic [XLEN-1:0]       regs_q [NREGS];
  logic [NREGS*XLEN-1:0] regs_flat;

  logic                  arr_we;
  logic [AW-1:0]         arr_waddr;
  logic [XLEN-1:0]       arr_wdata;

  // Clear sequencer: walk ptr from 1 up to NREGS-1, then stop without wrapping.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == CLEAR) begin
      if (ptr_q == AW'(NREGS - 1)) state_d = READY;
      else                         ptr_d   = ptr_q + AW'(1);
    end
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= AW'(1);
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // Array write port: sequencer clears own the port while busy; user writes otherwise.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = rd;
    arr_wdata = rd_wr_data;
    if (!rst) begin
      if (state_q == CLEAR) begin
        arr_we    = 1'b1;
        arr_waddr = ptr_q;
        arr_wdata = '0;
      end else if (rd_wr_en && (rd != '0)) begin
        arr_we = 1'b1;
      end
    end
  end

  // The array is deliberately outside the reset; only the sequencer clears it.
  always_ff @(posedge clk) begin
    if (arr_we) regs_q[arr_waddr] <= arr_wdata;
  end

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NREGS; i++) regs_flat[i*XLEN +: XLEN] = regs_q[i];
  end

`ifdef REGS_MP_BYPASS_EN
  logic usr_we;
  assign usr_we = !rst && (state_q == READY) && rd_wr_en && (rd != '0);
`endif

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regs_rd_port #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
    ) u_port (
      .clk       (clk),
      .rst       (rst),
      .busy      (busy_q),
      .rd_en     (rs_rd_en[p]),
      .addr      (rs_addr[p*AW +: AW]),
      .regs_flat (regs_flat),
`ifdef REGS_MP_BYPASS_EN
      .wr_en     (usr_we),
      .wr_addr   (rd),
      .wr_data   (rd_wr_data),
`endif
      .rd_data   (rs_rd_data[p*XLEN +: XLEN])
    );
  end

  assign busy = busy_q;

endmodule : regs_mp

// File: tb/tb_regs_mp.sv
// Self-checking bench for regs_mp: default configuration plus a second
// instance with NRD=4, NREGS=16, XLEN=64.
module tb_regs_mp;

`ifdef REGS_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic        rst;
  logic [1:0]  rs_rd_en;
  logic [9:0]  rs_addr;
  logic [4:0]  rd;
  logic [31:0] rd_wr_data;
  logic        rd_wr_en;
  logic [63:0] rs_rd_data;
  logic        busy;

  // Swept instance
  logic         rst2;
  logic [3:0]   rs_rd_en2;
  logic [15:0]  rs_addr2;
  logic [3:0]   rd2;
  logic [63:0]  rd_wr_data2;
  logic         rd_wr_en2;
  logic [255:0] rs_rd_data2;
  logic         busy2;

  regs_mp u_dut (
    .clk(clk), .rst(rst), .rs_rd_en(rs_rd_en), .rs_addr(rs_addr), .rd(rd),
    .rd_wr_data(rd_wr_data), .rd_wr_en(rd_wr_en), .rs_rd_data(rs_rd_data), .busy(busy)
  );

  regs_mp #(.XLEN(64), .NREGS(16), .NRD(4)) u_dut2 (
    .clk(clk), .rst(rst2), .rs_rd_en(rs_rd_en2), .rs_addr(rs_addr2), .rd(rd2),
    .rd_wr_data(rd_wr_data2), .rd_wr_en(rd_wr_en2), .rs_rd_data(rs_rd_data2), .busy(busy2)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [1:0]  en;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t tv [8];

  // Reference model state for the randomized phase
  logic [31:0] m_reg [32];
  logic [31:0] m_out [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic idle();
    rs_rd_en = '0; rs_addr = '0; rd = '0; rd_wr_data = '0; rd_wr_en = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] e [2];
    logic [1:0]  en;
    logic [4:0]  a [2];
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [63:0] v15;

    tv[0] = '{2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 32'h0000_1234, 32'h0, 32'h0};
    tv[1] = '{2'b00, 5'd0, 5'd0, 1'b1, 5'd1, 32'h0000_9876, 32'h0, 32'h0};
    tv[2] = '{2'b11, 5'd0, 5'd1, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0000_9876};
    tv[3] = '{2'b01, 5'd5, 5'd1, 1'b1, 5'd5, 32'hDEAD_BEEF,
              (BYP ? 32'hDEAD_BEEF : 32'h0), 32'h0000_9876};
    tv[4] = '{2'b01, 5'd5, 5'd1, 1'b0, 5'd0, 32'h0, 32'hDEAD_BEEF, 32'h0000_9876};
    tv[5] = '{2'b11, 5'd1, 5'd1, 1'b0, 5'd0, 32'h0, 32'h0000_9876, 32'h0000_9876};
    tv[6] = '{2'b00, 5'd5, 5'd5, 1'b1, 5'd1, 32'h0000_FFFF, 32'h0000_9876, 32'h0000_9876};
    tv[7] = '{2'b11, 5'd1, 5'd5, 1'b0, 5'd0, 32'h0, 32'h0000_FFFF, 32'hDEAD_BEEF};

    idle();
    rst = 1'b1;
    rst2 = 1'b1; rs_rd_en2 = '0; rs_addr2 = '0; rd2 = '0; rd_wr_data2 = '0; rd_wr_en2 = 1'b0;

    // Reset held 5 cycles, with a write attempt that must not land
    rd_wr_en = 1'b1; rd = 5'd7; rd_wr_data = 32'h7777_7777; rs_rd_en = 2'b11;
    repeat (5) tick();
    chk("reset_busy", 64'(busy), 64'd1);
    chk("reset_rdata", rs_rd_data, 64'd0);
    idle();
    rst = 1'b0;
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
    chk("clear_len", 64'(n), 64'd31);
    rs_rd_en = 2'b11; rs_addr = {5'd7, 5'd7};
    tick();
    chk("reset_wr_blocked", rs_rd_data, 64'd0);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      rs_rd_en = tv[i].en; rs_addr = {tv[i].a1, tv[i].a0};
      rd_wr_en = tv[i].we; rd = tv[i].wa; rd_wr_data = tv[i].wd;
      tick();
      chk($sformatf("vec%0d_p0", i), 64'(rs_rd_data[31:0]), 64'(tv[i].e0));
      chk($sformatf("vec%0d_p1", i), 64'(rs_rd_data[63:32]), 64'(tv[i].e1));
    end
    idle();

    // Fill all registers with nonzero data
    for (int i = 1; i < 32; i++) begin
      rd_wr_en = 1'b1; rd = 5'(i); rd_wr_data = 32'(i) * 32'h0101_0101;
      tick();
    end
    idle();
    rs_rd_en = 2'b01; rs_addr = {5'd0, 5'd20};
    tick();
    chk("fill_x20", 64'(rs_rd_data[31:0]), 64'(32'd20 * 32'h0101_0101));

    // Reset, then reassert at clear cycle 10; reads and writes ignored meanwhile
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rs_rd_en = 2'b11; rs_addr = {5'd2, 5'd20};
    for (int k = 1; k <= 10; k++) begin
      if (k >= 5) begin rd_wr_en = 1'b1; rd = 5'd2; rd_wr_data = 32'h0000_ABCD; end
      tick();
      chk($sformatf("midclr_busy%0d", k), 64'(busy), 64'd1);
      chk($sformatf("midclr_rd%0d", k), rs_rd_data, 64'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      tick(); n++;
      chk("busy_rd_zero", rs_rd_data, 64'd0);
    end
    chk("reclear_len", 64'(n), 64'd31);
    idle();

    // All registers cleared, including the one written at during busy
    for (int i = 1; i < 32; i++) begin
      rs_rd_en = 2'b11; rs_addr = {5'(i), 5'(i)};
      tick();
      chk($sformatf("zero_x%0d", i), rs_rd_data, 64'd0);
    end

    // Randomized phase against a behavioural model
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_out[0] = '0; m_out[1] = '0;
    for (int c = 0; c < 400; c++) begin
      en = 2'($urandom);
      a[0] = 5'($urandom);
      a[1] = ($urandom_range(0, 3) == 0) ? a[0] : 5'($urandom);
      we = 1'($urandom);
      wa = ($urandom_range(0, 3) == 0) ? a[0] : 5'($urandom_range(0, 7));
      wd = $urandom;
      for (int p = 0; p < 2; p++) begin
        if (!en[p])                        e[p] = m_out[p];
        else if (a[p] == 0)                e[p] = 32'h0;
        else if (BYP && we && wa == a[p])  e[p] = wd;
        else                               e[p] = m_reg[a[p]];
        m_out[p] = e[p];
      end
      if (we && wa != 0) m_reg[wa] = wd;
      rs_rd_en = en; rs_addr = {a[1], a[0]};
      rd_wr_en = we; rd = wa; rd_wr_data = wd;
      tick();
      chk($sformatf("rnd%0d_p0", c), 64'(rs_rd_data[31:0]), 64'(e[0]));
      chk($sformatf("rnd%0d_p1", c), 64'(rs_rd_data[63:32]), 64'(e[1]));
    end
    idle();

    // Swept configuration: NRD=4, NREGS=16, XLEN=64
    chk("p2_reset_busy", 64'(busy2), 64'd1);
    chk("p2_reset_rdata", 64'(|rs_rd_data2), 64'd0);
    rst2 = 1'b0;
    n = 0;
    while (busy2 && n < 200) begin tick(); n++; end
    chk("p2_clear_len", 64'(n), 64'd15);
    v15 = 64'hFFFF_FFFF_0000_0001;
    rd_wr_en2 = 1'b1; rd2 = 4'd15; rd_wr_data2 = v15;
    tick();
    rd_wr_en2 = 1'b0;
    rs_rd_en2 = 4'hF; rs_addr2 = {4'd15, 4'd15, 4'd15, 4'd15};
    tick();
    for (int p = 0; p < 4; p++)
      chk($sformatf("p2_x15_port%0d", p), rs_rd_data2[p*64 +: 64], v15);
    rs_addr2 = {4'd0, 4'd15, 4'd14, 4'd0};
    tick();
    chk("p2_mix_p0", rs_rd_data2[63:0], 64'd0);
    chk("p2_mix_p1", rs_rd_data2[127:64], 64'd0);
    chk("p2_mix_p2", rs_rd_data2[191:128], v15);
    chk("p2_mix_p3", rs_rd_data2[255:192], 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_regs_mp

// File: doc/regs_mp.md
REGS_MP -- requirements
Module: regs_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, 2..64.
REQ-003 SHALL have parameter NRD, default 2, number of read ports, 1..4.
REQ-004 SHALL derive localparam AW = $clog2(NREGS).
REQ-005 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port rs_rd_en  in  NRD  per-port read enable.
REQ-008 SHALL have port rs_addr  in  NRD*AW  read addresses; port p in bits [p*AW +: AW].
REQ-009 SHALL have port rd  in  AW  write address.
REQ-010 SHALL have port rd_wr_data  in  XLEN  write data.
REQ-011 SHALL have port rd_wr_en  in  1  write enable.
REQ-012 SHALL have port rs_rd_data  out  NRD*XLEN  registered read data; port p in [p*XLEN +: XLEN].
REQ-013 SHALL have port busy  out  1  high while the clear sequencer runs; accesses ignored.

Function
REQ-014 SHALL hard-wire x0 to zero: a write to address 0 has no effect, and a read of address 0 returns 0.
REQ-015 SHALL commit a write on the edge where rd_wr_en=1, busy=0 and rd!=0.
REQ-016 SHALL give read latency 1: with rs_rd_en[p]=1 and busy=0 at edge N, rs_rd_data[p] = x[rs_addr[p]] after edge N.
REQ-017 SHALL hold rs_rd_data[p] unchanged when rs_rd_en[p]=0.
REQ-018 SHALL keep read ports independent: identical addresses on several ports return identical data.
REQ-019 SHALL implement a two-state FSM: CLEAR and READY.
REQ-020 SHALL enter CLEAR with an internal pointer at 1 when rst=1.
REQ-021 SHALL zero x[ptr] on each CLEAR cycle and increment ptr by one.
REQ-022 SHALL move from CLEAR to READY on the edge that clears x[NREGS-1].
REQ-023 SHALL make CLEAR last NREGS-1 cycles after rst deasserts.
REQ-024 SHALL drive busy=1 exactly in CLEAR.
REQ-025 SHALL ignore rd_wr_en and rs_rd_en while busy=1, and SHALL hold rs_rd_data at 0 during that time.
REQ-026 SHALL return the pointer to 1 when rst is reasserted mid-CLEAR, with no wrap or skip.
REQ-027 SHALL not let the pointer wrap past NREGS-1.

Reset
REQ-028 SHALL set, on rst=1: state=CLEAR, ptr=1, busy=1, and all rs_rd_data=0.
REQ-029 SHALL not zero the register array in the reset branch; only the sequencer clears it.
REQ-030 SHALL block writes for the whole time rst=1.

Configuration
REQ-031 SHALL have a macro REGS_MP_BYPASS_EN that controls write-to-read forwarding.
REQ-032 SHALL, when REGS_MP_BYPASS_EN is defined: a read at the same edge as a write to the same nonzero address returns rd_wr_data.
REQ-033 SHALL, when REGS_MP_BYPASS_EN is undefined: that same read returns the old contents.
REQ-034 SHALL keep the new value visible from the next read in both builds.

Structure
REQ-035 SHALL place in package regs_pkg: the default constants XLEN_DEF=32 and NREGS_DEF=32, and the typedef regs_state_e {CLEAR, READY}.
REQ-036 SHALL use one sub-module, regs_rd_port, instantiated NRD times via generate; it holds the registered mux, the enable hold and the bypass compare.
REQ-037 SHALL keep the array, the write logic and the FSM in regs_mp.

Verification
REQ-038 Reset sequence: rst high 5 cycles, then low -> busy=1 for exactly 31 cycles (NREGS=32); x1..x31 all 0 afterwards.
REQ-039 Write x0 and read x0: write 0x1234 to x0, write 0x9876 to x1, then read port0=x0, port1=x1 -> 0x00000000 and 0x00009876.
REQ-040 Same-edge write and read: write 0xDEADBEEF to x5 while port0 reads x5 -> 0xDEADBEEF with bypass, prior value (0) without; next read gives 0xDEADBEEF in both builds.
REQ-041 Read enable hold: read x1 (0x9876), then rs_rd_en=0 with rs_addr changed to x5 -> rs_rd_data holds 0x9876.
REQ-042 Reset mid-clear: reassert rst at clear cycle 10 for 1 cycle -> busy stays high 31 more cycles; a write attempted during busy does not land.
REQ-043 Parameter sweep: NRD=4, NREGS=16, XLEN=64; write x15=0xFFFF_FFFF_0000_0001, then read it on all 4 ports -> all 4 ports match; CLEAR lasts 15 cycles.
